dht11_reading_manager: RTL and testbench
========================================

DHT11_READING_MANAGER -- requirements
Module: dht11_reading_manager

Interface
REQ-001 Parameter START_HOLD, default 128, sets the sensor_start high time in clk cycles.
REQ-002 Parameter TIMEOUT_CYCLES, default 2_000_000, sets the maximum wait for sensor completion in clk cycles.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  command request present.
REQ-006 req_cmd  input  3  command: 0 status, 1 humidity integer, 2 temperature integer, 3 humidity decimal, 4 temperature decimal; 5-7 invalid.
REQ-007 req_ready  output  1  block accepts a request.
REQ-008 sensor_start  output  1  measurement trigger to the DHT11 controller.
REQ-009 sensor_data  input  40  DHT11 frame {hum_int, hum_dec, temp_int, temp_dec, checksum}, MSB first.
REQ-010 sensor_done  input  1  completion pulse from the DHT11 controller; asynchronous to clk.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  downstream accepts the response.
REQ-013 resp_code  output  8  response code.
REQ-014 resp_value  output  8  response payload.
REQ-015 fault_count  output  8  count of sensor faults, saturating.

Function
REQ-016 FSM states: IDLE, START, WAIT, CHECK, RESP.
REQ-017 req_ready is 1 only in IDLE; a request is accepted on the cycle where req_valid and req_ready are both 1, and req_cmd is registered on that cycle.
REQ-018 An accepted command in 5-7 goes IDLE->RESP with resp_code 0xEF and resp_value 0x00; resp_valid is 1 on the next cycle and sensor_start stays 0.
REQ-019 An accepted command in 0-4 goes IDLE->START; sensor_start is 1 for exactly START_HOLD consecutive cycles, starting the cycle after acceptance.
REQ-020 START->WAIT when the hold completes; sensor_start is 0 in WAIT, and the timeout counter is cleared on entry to WAIT.
REQ-021 sensor_done passes through a 2-flop synchronizer followed by rising-edge detection; a detected edge is used 3 cycles after the input rises.
REQ-022 In WAIT, a detected done edge captures sensor_data into an internal frame register and moves to CHECK.
REQ-023 Done edges in any state other than WAIT are ignored and do not update the frame register.
REQ-024 In WAIT, if the timeout counter reaches TIMEOUT_CYCLES-1 with no done edge, the block goes to RESP with a fault response.
REQ-025 CHECK lasts one cycle; the checksum passes when frame[7:0] equals (frame[39:32]+frame[31:24]+frame[23:16]+frame[15:8]) mod 256, with 8-bit wrap-around.
REQ-026 Checksum pass: cmd 0 gives code 0x07, value 0x00; cmd 1 gives code 0x01, value frame[39:32]; cmd 2 gives code 0x02, value frame[23:16]; cmd 3 gives code 0x03, value frame[31:24]; cmd 4 gives code 0x04, value frame[15:8].
REQ-027 Fault (checksum fail or timeout): code 0x1F, value 0x00; fault_count increments by 1 and saturates at 0xFF.
REQ-028 In RESP, resp_valid is 1 and resp_code and resp_value are held stable until resp_ready is 1.
REQ-029 On the handshake cycle the block goes RESP->IDLE, and resp_valid is 0 on the following cycle.
REQ-030 If resp_ready is already 1 when RESP is entered, the response completes in one cycle.
REQ-031 req_valid while not in IDLE is not accepted, and the request is not queued.

Reset
REQ-032 rst_n low, at any time including mid-measurement, forces IDLE immediately.
REQ-033 Outputs under reset: sensor_start 0, resp_valid 0, resp_code 0x00, resp_value 0x00, fault_count 0x00.
REQ-034 Internal state under reset: frame register, counters and synchronizer flops all cleared to 0.
REQ-035 req_ready is 1 on the first clk edge after rst_n goes high.

Verification
REQ-036 req_cmd=1, done pulse with frame 0x2D_00_17_00_44 -> sensor_start high for 128 cycles, then resp_code 0x01, resp_value 0x2D, fault_count 0.
REQ-037 req_cmd=2, frame 0x2D_00_17_00_45 (bad checksum) -> resp_code 0x1F, resp_value 0x00, fault_count 1.
REQ-038 req_cmd=4, no done pulse -> resp_valid rises TIMEOUT_CYCLES cycles after WAIT entry with code 0x1F (run with TIMEOUT_CYCLES=1000).
REQ-039 req_cmd=6 -> next cycle resp_code 0xEF, sensor_start never asserted; resp_ready held low 20 cycles -> code and value stable throughout.
REQ-040 Checksum wrap frame 0xFF_FF_01_01_00 with req_cmd=0 -> resp_code 0x07.
REQ-041 rst_n low during WAIT, with a late done pulse after release -> frame register not updated, outputs at reset values, req_ready=1.
REQ-042 Force 256 faults -> fault_count saturates at 0xFF.

Source files
------------

// File: rtl/dht11_reading_manager.sv
// Command front-end for a DHT11 controller: triggers a measurement, waits for the
// frame, validates its checksum and returns the requested field as a response.
module dht11_reading_manager #(
  parameter int START_HOLD     = 128,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [2:0]  req_cmd,
  output logic        req_ready,
  output logic        sensor_start,
  input  logic [39:0] sensor_data,
  input  logic        sensor_done,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  resp_code,
  output logic [7:0]  resp_value,
  output logic [7:0]  fault_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  cmd;
  logic [31:0] hold_cnt;
  logic [31:0] to_cnt;
  logic [2:0]  done_sync;
  logic [39:0] frame;
  logic        done_edge;
  logic [7:0]  sum;
  logic [7:0]  fault_inc;

  // Two synchronizer flops plus one history flop for edge detection.
  assign done_edge = done_sync[1] & ~done_sync[2];

  assign req_ready    = (state == IDLE);
  assign sensor_start = (state == START);
  assign resp_valid   = (state == RESP);

  always_comb begin
    sum       = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    fault_inc = (fault_count == 8'hFF) ? 8'hFF : fault_count + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd         <= 3'd0;
      hold_cnt    <= 32'd0;
      to_cnt      <= 32'd0;
      done_sync   <= 3'd0;
      frame       <= 40'd0;
      resp_code   <= 8'h00;
      resp_value  <= 8'h00;
      fault_count <= 8'h00;
    end else begin
      done_sync <= {done_sync[1:0], sensor_done};
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd <= req_cmd;
            if (req_cmd > 3'd4) begin
              resp_code  <= 8'hEF;
              resp_value <= 8'h00;
              state      <= RESP;
            end else begin
              hold_cnt <= 32'd0;
              state    <= START;
            end
          end
        end
        START: begin
          if (hold_cnt == 32'(START_HOLD - 1)) begin
            to_cnt <= 32'd0;
            state  <= WAIT;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        WAIT: begin
          if (done_edge) begin
            frame <= sensor_data;
            state <= CHECK;
          end else if (to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            resp_code   <= 8'h1F;
            resp_value  <= 8'h00;
            fault_count <= fault_inc;
            state       <= RESP;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        CHECK: begin
          state <= RESP;
          if (frame[7:0] != sum) begin
            resp_code   <= 8'h1F;
            resp_value  <= 8'h00;
            fault_count <= fault_inc;
          end else begin
            case (cmd)
              3'd1:    begin resp_code <= 8'h01; resp_value <= frame[39:32]; end
              3'd2:    begin resp_code <= 8'h02; resp_value <= frame[23:16]; end
              3'd3:    begin resp_code <= 8'h03; resp_value <= frame[31:24]; end
              3'd4:    begin resp_code <= 8'h04; resp_value <= frame[15:8];  end
              default: begin resp_code <= 8'h07; resp_value <= 8'h00;        end
            endcase
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_reading_manager.sv
// Directed bench for dht11_reading_manager: a vector table of full transactions
// followed by hand-written reset, zero-wait handshake and saturation sequences.
module tb_dht11_reading_manager;

  localparam int HOLD = 128;
  localparam int TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_cmd = 3'd0;
  logic        req_ready;
  logic        sensor_start;
  logic [39:0] sensor_data = 40'd0;
  logic        sensor_done = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [7:0]  resp_code;
  logic [7:0]  resp_value;
  logic [7:0]  fault_count;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dht11_reading_manager #(.START_HOLD(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .sensor_start(sensor_start), .sensor_data(sensor_data),
    .sensor_done(sensor_done), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_code(resp_code), .resp_value(resp_value), .fault_count(fault_count)
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [39:0] frame;
    bit          done;
    bit          timeout;
    bit          poke;
    bit          early;
    int          stall;
    logic [7:0]  code;
    logic [7:0]  value;
    logic [7:0]  fault;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int n_start;
    int n;
    int bad;
    logic [7:0] c0;
    logic [7:0] v0;
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = v.cmd;
    @(negedge clk);
    req_valid = 1'b0;
    n_start = 0;
    while (sensor_start && n_start < 2000) begin
      if (v.poke && n_start == 10) begin req_valid = 1'b1; req_cmd = 3'd5; end
      if (v.poke && n_start == 13) req_valid = 1'b0;
      if (v.early && n_start == 20) begin sensor_data = 40'hAAAAAAAAAA; sensor_done = 1'b1; end
      if (v.early && n_start == 30) sensor_done = 1'b0;
      n_start++;
      @(negedge clk);
    end
    check("start_cycles", n_start, (v.cmd > 3'd4) ? 0 : HOLD);
    if (v.done) begin
      sensor_data = v.frame;
      sensor_done = 1'b1;
      repeat (4) @(negedge clk);
      sensor_done = 1'b0;
    end
    n = 0;
    while (!resp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (v.timeout) check("timeout_latency", n, TMO);
    if (v.cmd > 3'd4) check("invalid_latency", n, 0);
    check("resp_valid", {31'd0, resp_valid}, 1);
    check("resp_code", {24'd0, resp_code}, {24'd0, v.code});
    check("resp_value", {24'd0, resp_value}, {24'd0, v.value});
    check("fault_count", {24'd0, fault_count}, {24'd0, v.fault});
    c0 = resp_code;
    v0 = resp_value;
    bad = 0;
    repeat (v.stall) begin
      @(negedge clk);
      if (resp_code !== c0 || resp_value !== v0 || resp_valid !== 1'b1 || sensor_start !== 1'b0) bad++;
    end
    if (v.stall > 0) check("stall_stable", bad, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_drop", {31'd0, resp_valid}, 0);
    check("req_ready_after", {31'd0, req_ready}, 1);
    $display("txn cmd=%0d frame=%010h code=%02h value=%02h faults=%0d", v.cmd, v.frame,
             c0, v0, fault_count);
  endtask

  initial begin
    vec_t v;
    int n_start;
    vecs[0]  = '{3'd1, 40'h2D00170044, 1, 0, 0, 0, 0,  8'h01, 8'h2D, 8'h00};
    vecs[1]  = '{3'd2, 40'h2D00170045, 1, 0, 0, 0, 0,  8'h1F, 8'h00, 8'h01};
    vecs[2]  = '{3'd4, 40'h0000000000, 0, 1, 0, 0, 0,  8'h1F, 8'h00, 8'h02};
    vecs[3]  = '{3'd6, 40'h0000000000, 0, 0, 0, 0, 20, 8'hEF, 8'h00, 8'h02};
    vecs[4]  = '{3'd0, 40'hFFFF010100, 1, 0, 0, 0, 0,  8'h07, 8'h00, 8'h02};
    vecs[5]  = '{3'd3, 40'h3205190858, 1, 0, 1, 1, 0,  8'h03, 8'h05, 8'h02};
    vecs[6]  = '{3'd4, 40'h3205190858, 1, 0, 0, 0, 3,  8'h04, 8'h08, 8'h02};
    vecs[7]  = '{3'd2, 40'h3205190858, 1, 0, 0, 0, 0,  8'h02, 8'h19, 8'h02};
    vecs[8]  = '{3'd7, 40'h0000000000, 0, 0, 0, 0, 0,  8'hEF, 8'h00, 8'h02};
    vecs[9]  = '{3'd1, 40'h0000000000, 1, 0, 0, 0, 0,  8'h01, 8'h00, 8'h02};
    vecs[10] = '{3'd0, 40'h010203040A, 1, 0, 0, 0, 0,  8'h07, 8'h00, 8'h02};

    // Reset values
    #1;
    check("rst_sensor_start", {31'd0, sensor_start}, 0);
    check("rst_resp_valid", {31'd0, resp_valid}, 0);
    check("rst_resp_code", {24'd0, resp_code}, 0);
    check("rst_resp_value", {24'd0, resp_value}, 0);
    check("rst_fault_count", {24'd0, fault_count}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 1);
    $display("txn reset release req_ready=%0b", req_ready);

    foreach (vecs[i]) run_txn(vecs[i]);

    // resp_ready already high when RESP is entered
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = 3'd5;
    @(negedge clk);
    req_valid = 1'b0;
    check("zw_resp_valid", {31'd0, resp_valid}, 1);
    check("zw_resp_code", {24'd0, resp_code}, 8'hEF);
    @(negedge clk);
    check("zw_resp_valid_drop", {31'd0, resp_valid}, 0);
    resp_ready = 1'b0;
    $display("txn zero-wait handshake cmd=5");

    // Reset in the middle of WAIT, then a late done pulse
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = 3'd1;
    @(negedge clk);
    req_valid = 1'b0;
    n_start = 0;
    while (sensor_start && n_start < 2000) begin
      n_start++;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sensor_start", {31'd0, sensor_start}, 0);
    check("mid_rst_resp_valid", {31'd0, resp_valid}, 0);
    check("mid_rst_fault_count", {24'd0, fault_count}, 0);
    check("mid_rst_resp_code", {24'd0, resp_code}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sensor_data = 40'h2D00170044;
    sensor_done = 1'b1;
    repeat (6) @(negedge clk);
    sensor_done = 1'b0;
    repeat (3) @(negedge clk);
    check("late_done_resp_valid", {31'd0, resp_valid}, 0);
    check("late_done_sensor_start", {31'd0, sensor_start}, 0);
    check("late_done_req_ready", {31'd0, req_ready}, 1);
    check("late_done_resp_value", {24'd0, resp_value}, 0);
    $display("txn reset during wait, late done ignored");

    // Saturate the fault counter with bad-checksum frames
    for (int i = 0; i < 258; i++) begin
      v = '{3'd2, 40'h2D00170045, 1, 0, 0, 0, 0, 8'h1F, 8'h00,
            (i >= 254) ? 8'hFF : 8'(i + 1)};
      run_txn(v);
    end
    check("fault_saturated", {24'd0, fault_count}, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
